// File: rtl/roller_pkg.sv
// Shared types and constants for the roller-coaster checkpoint timing path.
package roller_pkg;

    localparam int N_CHECKPOINTS   = 5;
    localparam int LAST_CHECKPOINT = 4;
    localparam int CP_W            = 3;
    localparam int SPEED_W         = 9;
    localparam int DIV_W           = 24;

    typedef enum logic [2:0] {
        IDLE,
        TIMING,
        DIVIDE,
        DONE,
        FINISHED
    } state_t;

endpackage

// File: rtl/ir_speed_meter_if.sv
// Sensor inputs and measurement results of the IR speed meter.
interface ir_speed_meter_if;
    import roller_pkg::*;

    logic                     i_enable;
    logic [N_CHECKPOINTS-1:0] i_ir_raw;
    logic [SPEED_W-1:0]       o_speed;
    logic                     o_speed_valid;
    logic [CP_W-1:0]          o_checkpoint;
    logic                     o_destination;
    logic                     o_timeout;
    logic                     o_seq_error;
    logic                     o_busy;

    modport master (
        output i_enable, i_ir_raw,
        input  o_speed, o_speed_valid, o_checkpoint, o_destination,
               o_timeout, o_seq_error, o_busy
    );

    modport slave (
        input  i_enable, i_ir_raw,
        output o_speed, o_speed_valid, o_checkpoint, o_destination,
               o_timeout, o_seq_error, o_busy
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, fixed W-cycle latency.
// done is high during the final iteration; quotient is valid from the next cycle.
module seq_divider
    import roller_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int ITER_W = $clog2(W);

    logic [W-1:0]      rem;
    logic [W-1:0]      dsor;
    logic [ITER_W-1:0] iter;
    logic              busy;
    logic [W:0]        shifted;
    logic [W+1:0]      diff;

    assign shifted = {rem, quotient[W-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dsor};
    assign done    = busy && (iter == ITER_W'(W - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsor     <= '0;
            quotient <= '0;
            iter     <= '0;
            busy     <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            dsor     <= divisor;
            quotient <= dividend;
            iter     <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (diff[W+1]) begin
                rem      <= W'(shifted);
                quotient <= {quotient[W-2:0], 1'b0};
            end else begin
                rem      <= W'(diff);
                quotient <= {quotient[W-2:0], 1'b1};
            end
            iter <= iter + ITER_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_speed_meter.sv
// Conditions the five IR checkpoint sensors, times each track segment and
// reports segment speed = SEG_DIST / elapsed ticks, saturated to SPEED_MAX.
module ir_speed_meter
    import roller_pkg::*;
#(
    parameter int                 TICK_DIV      = 50,
    parameter int                 CNT_W         = 16,
    parameter logic [DIV_W-1:0]   SEG_DIST      = 24'd3000,
    parameter int                 DEBOUNCE      = 4,
    parameter logic [CNT_W-1:0]   TIMEOUT_TICKS = 16'd60000,
    parameter logic [SPEED_W-1:0] SPEED_MAX     = 9'd511
) (
    input logic             i_clk,
    input logic             i_rst,
    ir_speed_meter_if.slave bus
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [N_CHECKPOINTS-1:0] sync1, sync2, level, level_q, events, expected;
    logic [PRESC_W-1:0]       presc;
    logic [CNT_W-1:0]         elapsed;
    logic                     accept, dropped, div_start, div_done;
    logic [DIV_W-1:0]         div_divisor, quotient;

    state_t             state;
    logic [CP_W-1:0]    checkpoint, target;
    logic [SPEED_W-1:0] speed;
    logic               speed_valid, destination, timeout, seq_error, busy;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
        end else begin
            sync1   <= bus.i_ir_raw;
            sync2   <= sync1;
            level_q <= level;
        end
    end

    for (genvar g = 0; g < N_CHECKPOINTS; g++) begin : g_debounce
        logic [DB_W-1:0] stable_cnt;
        logic            lvl;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                stable_cnt <= '0;
                lvl        <= 1'b0;
            end else if (sync2[g] == lvl) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE - 1)) begin
                stable_cnt <= '0;
                lvl        <= sync2[g];
            end else begin
                stable_cnt <= stable_cnt + DB_W'(1);
            end
        end

        assign level[g] = lvl;
    end

    assign events = level & ~level_q;

    // Segment timebase restarts on each accepted checkpoint and keeps running through the divide.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            presc   <= '0;
            elapsed <= '0;
        end else if (accept) begin
            presc   <= '0;
            elapsed <= '0;
        end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
            presc <= '0;
            if (elapsed != '1) elapsed <= elapsed + CNT_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        expected = '0;
        accept   = 1'b0;
        dropped  = 1'b0;
        case (state)
            IDLE, FINISHED: expected = N_CHECKPOINTS'(1);
            TIMING:         expected = N_CHECKPOINTS'(1) << (checkpoint + CP_W'(1));
            default:        expected = '0;
        endcase
        if (bus.i_enable) begin
            accept  = |(events & expected);
            dropped = |(events & ~expected);
        end
    end

    assign div_start   = (state == TIMING) && accept;
    assign div_divisor = (elapsed == '0) ? DIV_W'(1) : DIV_W'(elapsed);

    seq_divider #(.W(DIV_W)) u_divider (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .start    (div_start),
        .abort    (!bus.i_enable),
        .dividend (SEG_DIST),
        .divisor  (div_divisor),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            checkpoint  <= '0;
            target      <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            destination <= 1'b0;
            timeout     <= 1'b0;
            seq_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            speed_valid <= 1'b0;
            seq_error   <= dropped;
            if (!bus.i_enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, FINISHED: if (accept) begin
                        checkpoint  <= '0;
                        timeout     <= 1'b0;
                        destination <= 1'b0;
                        state       <= TIMING;
                        busy        <= 1'b1;
                    end
                    TIMING: if (accept) begin
                        target <= checkpoint + CP_W'(1);
                        state  <= DIVIDE;
                    end else if (elapsed == TIMEOUT_TICKS) begin
                        timeout    <= 1'b1;
                        checkpoint <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                    DIVIDE: if (div_done) state <= DONE;
                    DONE: begin
                        speed       <= (quotient > DIV_W'(SPEED_MAX)) ? SPEED_MAX : SPEED_W'(quotient);
                        checkpoint  <= target;
                        speed_valid <= 1'b1;
                        if (target == CP_W'(LAST_CHECKPOINT)) begin
                            destination <= 1'b1;
                            state       <= FINISHED;
                            busy        <= 1'b0;
                        end else begin
                            state <= TIMING;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_speed       = speed;
    assign bus.o_speed_valid = speed_valid;
    assign bus.o_checkpoint  = checkpoint;
    assign bus.o_destination = destination;
    assign bus.o_timeout     = timeout;
    assign bus.o_seq_error   = seq_error;
    assign bus.o_busy        = busy;

endmodule

// File: tb/tb_ir_speed_meter.sv
// Directed bench for ir_speed_meter: stimulus pushes expected speed results,
// a negedge monitor pops and compares them whenever o_speed_valid is seen.
module tb_ir_speed_meter;
    import roller_pkg::*;

    localparam int               TICK_DIV = 2;
    localparam int               DEBOUNCE = 3;
    localparam logic [15:0]      TIMEOUT  = 16'd500;
    // Raw rise in cycle R -> event at R+2+DEBOUNCE -> valid visible 26 cycles later.
    localparam int               LAT      = 2 + DEBOUNCE + 26;

    typedef struct {
        logic [SPEED_W-1:0] speed;
        logic [CP_W-1:0]    cp;
        int                 due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   seq_err_cnt = 0;

    ir_speed_meter_if bus ();

    ir_speed_meter #(
        .TICK_DIV      (TICK_DIV),
        .CNT_W         (16),
        .SEG_DIST      (24'd3000),
        .DEBOUNCE      (DEBOUNCE),
        .TIMEOUT_TICKS (TIMEOUT),
        .SPEED_MAX     (9'd511)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int idx, input int t, input int len);
        wait_cycle(t);
        bus.i_ir_raw[idx] = 1'b1;
        wait_cycle(t + len);
        bus.i_ir_raw[idx] = 1'b0;
    endtask

    task automatic expect_speed(input logic [SPEED_W-1:0] spd, input logic [CP_W-1:0] cp, input int rise);
        sb_q.push_back('{speed: spd, cp: cp, due: rise + LAT});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.o_seq_error) seq_err_cnt <= seq_err_cnt + 1;
            if (bus.o_speed_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", 32'(bus.o_speed_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("speed", 32'(bus.o_speed), 32'(mon_e.speed));
                    check("valid_checkpoint", 32'(bus.o_checkpoint), 32'(mon_e.cp));
                    check("valid_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    int t, c, n, r;
    int          seg [4] = '{200, 120, 300, 600};
    logic [8:0]  spd [4] = '{9'd30, 9'd50, 9'd20, 9'd10};

    initial begin
        bus.i_enable = 1'b0;
        bus.i_ir_raw = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_speed", 32'(bus.o_speed), 32'd0);
        check("rst_valid", 32'(bus.o_speed_valid), 32'd0);
        check("rst_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        check("rst_destination", 32'(bus.o_destination), 32'd0);
        check("rst_timeout", 32'(bus.o_timeout), 32'd0);
        check("rst_seq_error", 32'(bus.o_seq_error), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        wait_cycle(4);
        rst = 1'b1;
        bus.i_enable = 1'b1;

        // 100-tick segment 0 -> 1
        t = cyc + 5;
        pulse(0, t, 20);
        check("start_busy", 32'(bus.o_busy), 32'd1);
        check("start_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        expect_speed(9'd30, 3'd1, t + 200);
        pulse(1, t + 200, 20);
        wait_cycle(t + 200 + LAT + 4);
        check("seg1_checkpoint", 32'(bus.o_checkpoint), 32'd1);
        check("seg1_speed", 32'(bus.o_speed), 32'd30);
        check("seg1_busy", 32'(bus.o_busy), 32'd1);

        // Asynchronous reset while the next segment is being divided
        t = cyc + 5;
        pulse(2, t, 8);
        wait_cycle(t + 15);
        check("divide_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_speed", 32'(bus.o_speed), 32'd0);
        check("midrst_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_valid", 32'(bus.o_speed_valid), 32'd0);
        wait_cycle(cyc + 1);
        rst = 1'b1;
        wait_cycle(t + 60);
        check("post_rst_busy", 32'(bus.o_busy), 32'd0);

        // 5-tick segment saturates
        t = cyc + 5;
        pulse(0, t, 5);
        expect_speed(9'd511, 3'd1, t + 10);
        pulse(1, t + 10, 5);
        wait_cycle(t + 10 + LAT + 3);
        check("sat_speed", 32'(bus.o_speed), 32'd511);

        // Enable low: back to idle, results held, events ignored silently
        c = cyc;
        bus.i_enable = 1'b0;
        wait_cycle(c + 2);
        check("dis_busy", 32'(bus.o_busy), 32'd0);
        n = seq_err_cnt;
        pulse(2, c + 4, 6);
        wait_cycle(c + 20);
        check("dis_speed_held", 32'(bus.o_speed), 32'd511);
        check("dis_checkpoint_held", 32'(bus.o_checkpoint), 32'd1);
        check("dis_no_seq_error", seq_err_cnt - n, 0);
        bus.i_enable = 1'b1;

        // Glitch on sensor 1, then out-of-order sensor 3
        t = cyc + 5;
        pulse(0, t, 10);
        pulse(1, t + 30, 2);
        wait_cycle(t + 60);
        check("glitch_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        check("glitch_busy", 32'(bus.o_busy), 32'd1);
        n = seq_err_cnt;
        wait_cycle(t + 80);
        bus.i_ir_raw[3] = 1'b1;
        wait_cycle(t + 86);
        check("seq_error_pulse", 32'(bus.o_seq_error), 32'd1);
        wait_cycle(t + 87);
        check("seq_error_end", 32'(bus.o_seq_error), 32'd0);
        wait_cycle(t + 90);
        bus.i_ir_raw[3] = 1'b0;
        wait_cycle(t + 110);
        check("seq_error_count", seq_err_cnt - n, 1);
        check("ooo_checkpoint", 32'(bus.o_checkpoint), 32'd0);

        bus.i_enable = 1'b0;
        wait_cycle(cyc + 3);
        bus.i_enable = 1'b1;

        // Full run 0..4
        t = cyc + 5;
        pulse(0, t, 20);
        r = t;
        for (int i = 0; i < 4; i++) begin
            r += seg[i];
            expect_speed(spd[i], CP_W'(i + 1), r);
            pulse(i + 1, r, 20);
        end
        wait_cycle(r + LAT + 5);
        check("fin_destination", 32'(bus.o_destination), 32'd1);
        check("fin_checkpoint", 32'(bus.o_checkpoint), 32'd4);
        check("fin_busy", 32'(bus.o_busy), 32'd0);
        wait_cycle(r + LAT + 50);
        check("fin_speed_held", 32'(bus.o_speed), 32'd10);

        // Restart from FINISHED, then let the run time out
        t = cyc + 5;
        pulse(0, t, 20);
        check("restart_destination", 32'(bus.o_destination), 32'd0);
        check("restart_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        check("restart_busy", 32'(bus.o_busy), 32'd1);
        wait_cycle(t + 5 + 995);
        check("pre_timeout", 32'(bus.o_timeout), 32'd0);
        wait_cycle(t + 5 + 1010);
        check("timeout", 32'(bus.o_timeout), 32'd1);
        check("timeout_checkpoint", 32'(bus.o_checkpoint), 32'd0);
        check("timeout_busy", 32'(bus.o_busy), 32'd0);
        check("timeout_speed_held", 32'(bus.o_speed), 32'd10);

        wait_cycle(cyc + 5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_speed_meter.md
Name: ir_speed_meter

Overview:
Upstream stage of the roller-coaster display/alarm top level. Takes the five raw IR checkpoint sensors along the track and produces three things for the existing speed-band checks and LED7 speed display:
- the index of the last checkpoint passed;
- a measured speed for the segment just completed;
- a destination flag.
Speed is SEG_DIST divided by the segment time in ticks, computed with a sequential restoring divider.

Parameters:
TICK_DIV, 50, i_clk cycles per timing tick (prescaler)
CNT_W, 16, elapsed-tick counter width
SEG_DIST, 24'd3000, distance constant; speed = SEG_DIST / elapsed_ticks
DEBOUNCE, 4, cycles a synchronised sensor bit must be stable before it is accepted
TIMEOUT_TICKS, 16'd60000, ticks without the expected checkpoint before the run is aborted
SPEED_MAX, 9'd511, saturation value of o_speed

Ports:
i_clk  in  1  system clock (divided clock used by the top level)
i_rst  in  1  asynchronous, active-low reset
i_enable  in  1  measurement enable; low forces IDLE
i_ir_raw  in  5  raw beam-broken flags, bit n = checkpoint n, asynchronous to i_clk
o_speed  out  9  last computed segment speed, saturated to SPEED_MAX
o_speed_valid  out  1  one-cycle pulse when o_speed updates
o_checkpoint  out  3  last checkpoint passed, 0..4
o_destination  out  1  high after checkpoint 4 is processed
o_timeout  out  1  sticky abort flag
o_seq_error  out  1  one-cycle pulse on an unexpected or dropped sensor event
o_busy  out  1  high in TIMING, DIVIDE and DONE

Behaviour:
- Reset (i_rst low, asynchronous): every output is 0; FSM goes to IDLE; prescaler, elapsed counter, divider and debouncers are cleared.
- Input conditioning, per bit:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE consecutive equal synchronised samples.
  - An event is a debounced 0->1 transition. A raw rise held from cycle R gives an event in cycle E = R+2+DEBOUNCE.
- Expected sensor:
  - IDLE and FINISHED expect 0.
  - TIMING expects o_checkpoint+1.
  - Any other event in the same cycle, and any event in DIVIDE or DONE, is dropped. Each dropped event pulses o_seq_error once; simultaneous dropped events produce one pulse.
- Timebase: the prescaler counts 0..TICK_DIV-1. elapsed increments on wrap and saturates at 2^CNT_W-1. Both clear on every accepted event.
- FSM:
  - IDLE, sensor 0 event:
    - o_checkpoint<=0, o_timeout<=0, o_destination<=0;
    - go to TIMING;
    - no valid pulse.
  - TIMING:
    - Expected event: latch divisor = max(elapsed,1), latch target index, go to DIVIDE.
    - elapsed==TIMEOUT_TICKS: o_timeout<=1, o_checkpoint<=0, go to IDLE.
  - DIVIDE:
    - 24 iterations of restoring division, one per cycle, occupying cycles E+1..E+24.
    - elapsed keeps counting from 0, so the next segment is timed.
    - Then go to DONE.
  - DONE (cycle E+25):
    - o_speed <= min(quotient, SPEED_MAX); o_checkpoint <= target; o_speed_valid=1. These are visible in cycle E+26, and o_speed_valid is high for exactly that cycle.
    - If target==4: o_destination<=1, go to FINISHED. Otherwise return to TIMING.
  - FINISHED: holds all outputs. A sensor 0 event behaves exactly as in IDLE.
- i_enable low:
  - Synchronous transition to IDLE from any state; an in-flight divide is discarded.
  - o_speed, o_checkpoint, o_destination and o_timeout hold their values; o_busy falls.
  - Events are ignored with no error pulse.
- Arithmetic:
  - Quotient is 24-bit unsigned; the remainder is discarded.
  - Saturation applies when quotient > SPEED_MAX.
  - A divisor of 0 cannot occur because of the max(elapsed,1) clamp.

Decomposition:
- Shared package roller_pkg holds:
  - FSM state typedef (IDLE, TIMING, DIVIDE, DONE, FINISHED);
  - N_CHECKPOINTS=5 and LAST_CHECKPOINT=4;
  - speed width 9.
- Sub-module seq_divider: 24-bit restoring divider with start/done handshake and fixed 24-cycle latency. It is reusable for the weight-to-BCD path.
- Debouncer stays inline as a per-bit generate loop.

Test Plan:
All scenarios use TICK_DIV=2, DEBOUNCE=3, SEG_DIST=3000, TIMEOUT_TICKS=500.
1. Reset mid-DIVIDE (i_rst low 1 cycle) -> all outputs 0 immediately; no valid pulse afterwards.
2. Sensor 0 rise, then sensor 1 rise 200 cycles later (100 ticks) -> o_speed=30, o_checkpoint=1, o_speed_valid high exactly one cycle, at E+26.
3. Sensor 1 five ticks after sensor 0 -> quotient 600 saturates, so o_speed=511.
4. Sensor 1 raw pulse of 2 cycles -> no event, state stays TIMING; then sensor 3 pulse of 10 cycles while expecting 1 -> o_seq_error one pulse, o_checkpoint unchanged.
5. Full run 0..4 at 100, 60, 150, 300 ticks -> speeds 30, 50, 20, 10 in order, o_destination=1, FINISHED; a new sensor 0 clears o_destination.
6. Sensor 0, then nothing for 500 ticks -> o_timeout=1, o_checkpoint=0, IDLE; i_enable low during TIMING -> IDLE, o_busy=0, outputs held.
